// File: rtl/tbb_bus_writer.sv
// rtl/tbb_bus_writer.sv - command FIFO and nibble serialiser for the 4-bit sound-chip write bus
// Each queued (addr, data) command becomes three timed bus writes: addr, data[3:0], data[7:4].
module tbb_bus_writer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_addr,
  input  logic [7:0]                    cmd_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [3:0]                    D,
  output logic                          A0,
  output logic                          WR_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
  localparam logic [3:0]    SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0]    STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0]    HOLD_LAST   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  phase_q, phase_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  d_q, d_d;
  logic        a0_q, a0_d;
  logic        wr_n_q, wr_n_d;

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count;
  logic [11:0]   head;
  logic          fifo_empty, push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count      = wptr_q - rptr_q;
  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign wptr_d     = wptr_q + CW'(push);
  assign rptr_d     = rptr_q + CW'(pop);

  assign fifo_count = count;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign D          = d_q;
  assign A0         = a0_q;
  assign WR_n       = wr_n_q;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      phase_q <= 4'd0;
      data_q  <= 8'd0;
      d_q     <= 4'd0;
      a0_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      d_q     <= d_d;
      a0_q    <= a0_d;
      wr_n_q  <= wr_n_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    data_d  = data_q;
    d_d     = d_q;
    a0_d    = a0_q;
    wr_n_d  = wr_n_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_n_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = head[7:0];
          idx_d   = 2'd0;
          d_d     = head[11:8];
          a0_d    = 1'b0;
          phase_d = 4'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d = 4'd0;
          wr_n_d  = 1'b0;
          state_d = STROBE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      STROBE: begin
        if (phase_q == STROBE_LAST) begin
          phase_d = 4'd0;
          wr_n_d  = 1'b1;
          state_d = HOLD;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      HOLD: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = 4'd0;
          if (idx_q != 2'd2) begin
            idx_d   = idx_q + 2'd1;
            a0_d    = 1'b1;
            d_d     = (idx_q == 2'd0) ? data_q[3:0] : data_q[7:4];
            state_d = SETUP;
          end else if (!fifo_empty) begin
            // Chain straight into the next command without an IDLE cycle.
            pop     = 1'b1;
            data_d  = head[7:0];
            idx_d   = 2'd0;
            d_d     = head[11:8];
            a0_d    = 1'b0;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
    endcase
  end

endmodule
